// File: rtl/key_press_classifier.sv
// Turns a debounced active-low key level into one-cycle short, double, long
// and auto-repeat pulses using a single shared duration counter.
module key_press_classifier #(
    parameter int               CNT_W       = 27,
    parameter logic [CNT_W-1:0] LONG_CNT    = 27'd75_000_000,
    parameter logic [CNT_W-1:0] DBL_GAP_CNT = 27'd15_000_000,
    parameter logic [CNT_W-1:0] REPEAT_CNT  = 27'd5_000_000
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic key_filter,
    output logic short_press,
    output logic double_press,
    output logic long_press,
    output logic repeat_press,
    output logic key_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESS1,
        S_WAIT2,
        S_PRESS2,
        S_LONG
    } state_e;

    localparam logic [CNT_W-1:0] LONG_LAST   = LONG_CNT - 1'b1;
    localparam logic [CNT_W-1:0] GAP_LAST    = DBL_GAP_CNT - 1'b1;
    localparam logic [CNT_W-1:0] REPEAT_LAST = REPEAT_CNT - 1'b1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             key_d_q;
    logic             short_q, short_d;
    logic             double_q, double_d;
    logic             long_q, long_d;
    logic             repeat_q, repeat_d;
    logic             busy_q, busy_d;
    logic             fall, rise;

    // key_d_q resets low so a key already held at reset release never looks like a fresh press
    assign fall = key_d_q & ~key_filter;
    assign rise = ~key_d_q & key_filter;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        short_d  = 1'b0;
        double_d = 1'b0;
        long_d   = 1'b0;
        repeat_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (fall) begin
                    state_d = S_PRESS1;
                    cnt_d   = '0;
                end
            end
            S_PRESS1: begin
                if (rise) begin
                    state_d = S_WAIT2;
                    cnt_d   = '0;
                end else if (cnt_q == LONG_LAST) begin
                    state_d = S_LONG;
                    cnt_d   = '0;
                    long_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT2: begin
                if (fall) begin
                    state_d = S_PRESS2;
                    cnt_d   = '0;
                end else if (cnt_q == GAP_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    short_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_PRESS2: begin
                if (rise) begin
                    state_d  = S_IDLE;
                    cnt_d    = '0;
                    double_d = 1'b1;
                end
            end
            S_LONG: begin
                // Release takes priority over a repeat that would fire on the same edge
                if (rise) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == REPEAT_LAST) begin
                    cnt_d    = '0;
                    repeat_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            key_d_q  <= 1'b0;
            short_q  <= 1'b0;
            double_q <= 1'b0;
            long_q   <= 1'b0;
            repeat_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            key_d_q  <= key_filter;
            short_q  <= short_d;
            double_q <= double_d;
            long_q   <= long_d;
            repeat_q <= repeat_d;
            busy_q   <= busy_d;
        end
    end

    assign short_press  = short_q;
    assign double_press = double_q;
    assign long_press   = long_q;
    assign repeat_press = repeat_q;
    assign key_busy     = busy_q;

endmodule

// File: tb/tb_key_press_classifier.sv
// Randomised gesture bench for key_press_classifier: a gesture-level model
// predicts pulse times and busy windows; a monitor checks them cycle by cycle.
module tb_key_press_classifier;

    localparam int LONG = 20;
    localparam int GAP  = 10;
    localparam int REP  = 5;

    localparam int K_SHORT  = 0;
    localparam int K_DOUBLE = 1;
    localparam int K_LONG   = 2;
    localparam int K_REPEAT = 3;

    typedef struct {
        int t;
        int kind;
    } ev_t;

    logic sys_clk = 1'b0;
    logic sys_rst;
    logic key_filter;
    logic short_press, double_press, long_press, repeat_press, key_busy;

    bit   kq[$];
    bit   rq[$];
    bit   busyExp[$];
    ev_t  expQ[$];
    bit   ready = 1'b0;
    int   tests = 0;
    int   fails = 0;

    key_press_classifier #(
        .CNT_W      (27),
        .LONG_CNT   (27'd20),
        .DBL_GAP_CNT(27'd10),
        .REPEAT_CNT (27'd5)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .key_filter  (key_filter),
        .short_press (short_press),
        .double_press(double_press),
        .long_press  (long_press),
        .repeat_press(repeat_press),
        .key_busy    (key_busy)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic addRun(input bit level, input int len, input bit rst);
        for (int i = 0; i < len; i++) begin
            kq.push_back(level);
            rq.push_back(rst);
        end
    endtask

    function automatic bit prevK(input int n);
        if (n == 0 || rq[n-1]) return 1'b0;
        return kq[n-1];
    endfunction

    function automatic int findFall(input int from, input int lim);
        for (int i = from; i < lim; i++)
            if (!rq[i] && prevK(i) && !kq[i]) return i;
        return lim;
    endfunction

    function automatic int findRise(input int from, input int lim);
        for (int i = from; i < lim; i++)
            if (!rq[i] && !prevK(i) && kq[i]) return i;
        return lim;
    endfunction

    task automatic pushEv(input int t, input int kind);
        ev_t e;
        e.t    = t;
        e.kind = kind;
        expQ.push_back(e);
    endtask

    task automatic setBusy(input int a, input int b);
        for (int i = a; i < b; i++) busyExp[i] = 1'b1;
    endtask

    // Classifies each gesture from press/release durations; a reset cuts the gesture short
    task automatic runModel();
        int n, segEnd, pos, f, r1, f2, r2, endL, to;
        for (int i = 0; i < kq.size(); i++) busyExp.push_back(1'b0);
        n = 0;
        while (n < kq.size()) begin
            if (rq[n]) begin
                n++;
                continue;
            end
            segEnd = n;
            while (segEnd < kq.size() && !rq[segEnd]) segEnd++;
            pos = n;
            forever begin
                f = findFall(pos, segEnd);
                if (f >= segEnd) break;
                r1   = findRise(f + 1, segEnd);
                endL = r1;
                if (f + LONG < endL) begin
                    pushEv(f + LONG, K_LONG);
                    for (int t = f + LONG + REP; t < endL; t += REP) pushEv(t, K_REPEAT);
                    setBusy(f, endL);
                    pos = endL;
                end else if (r1 >= segEnd) begin
                    setBusy(f, segEnd);
                    pos = segEnd;
                end else begin
                    f2 = findFall(r1 + 1, segEnd);
                    to = r1 + GAP;
                    if (f2 <= to && f2 < segEnd) begin
                        r2 = findRise(f2 + 1, segEnd);
                        if (r2 < segEnd) pushEv(r2, K_DOUBLE);
                        setBusy(f, r2);
                        pos = r2;
                    end else if (to < segEnd) begin
                        pushEv(to, K_SHORT);
                        setBusy(f, to);
                        pos = to;
                    end else begin
                        setBusy(f, segEnd);
                        pos = segEnd;
                    end
                end
            end
            n = segEnd;
        end
    endtask

    task automatic applyStimulus();
        sys_rst    = rq[0];
        key_filter = kq[0];
        for (int n = 1; n < kq.size(); n++) begin
            @(negedge sys_clk);
            sys_rst    = rq[n];
            key_filter = kq[n];
        end
    endtask

    task automatic checkOutput(input int n);
        logic [3:0] pulses, expVec;
        ev_t        e;
        tests++;
        if (key_busy !== busyExp[n]) begin
            fails++;
            $display("[TB] FAIL busy@%0d got %0b expected %0b", n, key_busy, busyExp[n]);
        end
        pulses = {short_press, double_press, long_press, repeat_press};
        if (pulses !== 4'b0000) begin
            tests++;
            if (expQ.size() == 0) begin
                fails++;
                $display("[TB] FAIL unexpected_pulse@%0d got %b expected none", n, pulses);
            end else begin
                e      = expQ.pop_front();
                expVec = 4'b1000 >> e.kind;
                if (pulses !== expVec || e.t != n) begin
                    fails++;
                    $display("[TB] FAIL pulse@%0d got %b expected %b at cycle %0d",
                             n, pulses, expVec, e.t);
                end
            end
        end
    endtask

    initial begin
        // Directed gestures covering the boundary cases, then random gestures
        addRun(1'b1, 3, 1'b1);
        addRun(1'b1, 5, 1'b0);
        addRun(1'b0, 5, 1'b0);  addRun(1'b1, 20, 1'b0);
        addRun(1'b0, 5, 1'b0);  addRun(1'b1, 4, 1'b0);
        addRun(1'b0, 5, 1'b0);  addRun(1'b1, 20, 1'b0);
        addRun(1'b0, 33, 1'b0); addRun(1'b1, 20, 1'b0);
        addRun(1'b0, LONG, 1'b0); addRun(1'b1, 20, 1'b0);
        addRun(1'b0, 5, 1'b0);  addRun(1'b1, GAP, 1'b0);
        addRun(1'b0, 5, 1'b0);  addRun(1'b1, 20, 1'b0);
        addRun(1'b0, 4, 1'b0);  addRun(1'b0, 3, 1'b1);
        addRun(1'b0, 6, 1'b0);  addRun(1'b1, 15, 1'b0);
        addRun(1'b0, 5, 1'b0);  addRun(1'b1, 20, 1'b0);
        addRun(1'b0, 5, 1'b0);  addRun(1'b1, 3, 1'b0);
        addRun(1'b1, 1, 1'b1);  addRun(1'b1, 20, 1'b0);
        for (int g = 0; g < 60; g++) begin
            if ($urandom_range(0, 9) == 0)
                addRun(1'($urandom_range(0, 1)), $urandom_range(1, 2), 1'b1);
            addRun(1'b0, $urandom_range(1, 45), 1'b0);
            addRun(1'b1, $urandom_range(1, 25), 1'b0);
        end
        addRun(1'b1, 40, 1'b0);
        runModel();
        ready = 1'b1;
        applyStimulus();
    end

    initial begin
        wait (ready);
        for (int n = 0; n < kq.size(); n++) begin
            @(posedge sys_clk);
            #1;
            checkOutput(n);
        end
        tests++;
        if (expQ.size() != 0) begin
            fails++;
            $display("[TB] FAIL missing_pulses got 0 expected %0d more (next at cycle %0d)",
                     expQ.size(), expQ[0].t);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/key_press_classifier.md
Name: key_press_classifier

Overview:
- Sits directly downstream of the key debounce stage and consumes its debounced, active-low key level.
- Classifies each gesture as one of four events and emits a one-cycle pulse for it:
  - short press
  - double press
  - long press
  - auto-repeat while a long press is held
- The beep/LED control logic above it reacts only to these pulses and never sees raw key levels.

Parameters:
- CNT_W, 27, width of the shared duration counter.
- LONG_CNT, 27'd75_000_000, hold time for a long press in sys_clk cycles (1.5 s at 50 MHz).
- DBL_GAP_CNT, 27'd15_000_000, maximum release gap for a double press (300 ms).
- REPEAT_CNT, 27'd5_000_000, auto-repeat period after a long press (100 ms).

Ports:
- sys_clk  input  1  system clock, 50 MHz.
- sys_rst  input  1  synchronous, active-high reset.
- key_filter  input  1  debounced key level; 0 = pressed, 1 = released; already synchronous to sys_clk.
- short_press  output  1  one-cycle pulse: single short press.
- double_press  output  1  one-cycle pulse: two short presses within the gap.
- long_press  output  1  one-cycle pulse: key held LONG_CNT cycles.
- repeat_press  output  1  one-cycle pulse every REPEAT_CNT cycles while a long press continues.
- key_busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Clocking and reset:
  - One clock domain; all state on posedge sys_clk.
  - Reset is synchronous and active-high: while sys_rst = 1 at a clock edge, the block returns to its reset state on that edge.
- Edge detection:
  - key_d is key_filter delayed one cycle.
  - fall = key_d & ~key_filter; rise = ~key_d & key_filter.
  - key_d resets to 0, so a key held low through reset release is not seen as a press.
- Reset values:
  - state = IDLE, cnt = 0, key_d = 0.
  - short_press, double_press, long_press, repeat_press and key_busy are all 0.
- All outputs are registered. Pulses last exactly one cycle and appear on the edge that performs the named transition.
- FSM, one shared counter cnt[CNT_W-1:0], cleared on every state change:
  - IDLE:
    - fall -> PRESS1.
    - rise is ignored.
  - PRESS1:
    - cnt increments each cycle.
    - rise -> WAIT2.
    - else if cnt == LONG_CNT-1 -> LONG, and long_press = 1.
    - If rise and cnt == LONG_CNT-1 occur in the same cycle, rise wins: go to WAIT2, no long_press.
  - WAIT2:
    - cnt increments each cycle.
    - fall -> PRESS2.
    - else if cnt == DBL_GAP_CNT-1 -> IDLE, and short_press = 1.
    - If fall coincides with timeout, fall wins: go to PRESS2, no short_press.
  - PRESS2:
    - Wait for release, with no duration limit.
    - rise -> IDLE, and double_press = 1.
  - LONG:
    - cnt increments each cycle.
    - When cnt == REPEAT_CNT-1: repeat_press = 1 and cnt <= 0.
    - rise -> IDLE with no pulse; rise wins over a coinciding repeat.
- Timing:
  - long_press fires LONG_CNT cycles after the edge that entered PRESS1.
  - The first repeat_press fires REPEAT_CNT cycles after long_press, then every REPEAT_CNT cycles.
- key_busy = (next state != IDLE), registered, so it is high from the entry edge of PRESS1 until the edge that returns to IDLE.
- At most one pulse output is high in any cycle.
- Counter width: CNT_W must hold max(LONG_CNT, DBL_GAP_CNT, REPEAT_CNT); cnt never wraps because every state clears it at its terminal value.
- Reset mid-operation: all pending events are discarded, with no pulse on or after the reset edge. The key must be released and pressed again before any new event.

Test Plan (LONG_CNT=20, DBL_GAP_CNT=10, REPEAT_CNT=5):
- Short press: key low 5 cycles, then high -> exactly one short_press, 10 cycles after WAIT2 entry. No other pulses; key_busy drops on the same edge.
- Double press: key low 5, high 4, low 5, high -> one double_press on the edge after the second rise-detect cycle. No short_press.
- Long press with repeat: key low 33 cycles -> long_press 20 cycles after PRESS1 entry, repeat_press at +5 and +10 after long_press. Release gives no further pulse and no short_press.
- PRESS1 boundary: release coincides with cnt == 19 -> no long_press; short_press 10 cycles later.
- WAIT2 boundary: re-press coincides with cnt == 9 -> no short_press; double_press after release.
- Reset cases:
  - Key low while sys_rst deasserts -> no pulses while held or on release. A fresh press/release produces a short_press.
  - sys_rst pulsed mid-WAIT2 -> no short_press, and key_busy = 0 the cycle after reset.
